// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : fetch_pkg                                                   |
// | Purpose    : Shared types and constants for the instruction-fetch        |
// |              responder: FSM state encoding, the address/data entry       |
// |              carried through the skid register, and the reset level.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  // Default bus widths (instruction address bus / instruction word).
  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SKID = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fetch_skid_buf                                              |
// | Purpose    : One-entry holding register for an instruction that returns  |
// |              from memory while decode is stalled.                        |
// | Ports      : clk, rst   - clock, synchronous active-low reset            |
// |              load       - capture din, mark entry valid                  |
// |              drain      - entry consumed, mark invalid                   |
// |              clear      - discard entry (flush), wins over load          |
// |              din/dout   - entry in / held entry out                      |
// |              vld        - entry is live                                  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  ENTRY_T din,
  output ENTRY_T dout,
  output logic   vld
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      vld  <= 1'b0;
      dout <= '0;
    end else begin
      if (clear || drain) begin
        vld <= 1'b0;
      end else if (load) begin
        vld <= 1'b1;
      end
      if (load && !clear) begin
        dout <= din;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : inst_fetch_resp                                             |
// | Purpose    : Issues PC-driven reads to a 1-cycle synchronous instruction |
// |              memory and presents returned words to decode in order,      |
// |              holding under stall (via a skid entry) and squashing the    |
// |              wrong path on branch_true.                                  |
// | Ports      : clk, rst          - clock, synchronous active-low reset     |
// |              pc_addr           - current PC                              |
// |              stall,branch_true - pipeline stall / redirect               |
// |              mem_ce, mem_addr  - memory read request (combinational)     |
// |              mem_rdata         - read data, one cycle after mem_ce       |
// |              inst_valid/addr/data - registered instruction to decode     |
// |              fetch_cnt         - registered count of delivered words     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module inst_fetch_resp
  import fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              stall,
  input  logic              branch_true,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic [CNT_W-1:0]  fetch_cnt
);

  // Same layout as fetch_entry_t, sized to this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  fetch_state_t      state;
  logic              inflight_vld;
  logic [ADDR_W-1:0] inflight_addr;

  entry_t            ret_entry;
  entry_t            skid_dout;
  logic              skid_vld;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_clear;

  // No issue while draining the skid entry, so a new return can never
  // collide with the drain; no issue during a flush cycle either.
  assign mem_ce   = (rst != RST_ENABLE) && !stall && !branch_true && (state != S_SKID);
  assign mem_addr = pc_addr;

  assign ret_entry  = '{addr: inflight_addr, data: mem_rdata};
  assign skid_load  = (state == S_RUN) && stall && inflight_vld;
  assign skid_drain = (state == S_SKID) && !stall;
  assign skid_clear = branch_true;

  fetch_skid_buf #(
    .ENTRY_T (entry_t)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (ret_entry),
    .dout  (skid_dout),
    .vld   (skid_vld)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state         <= S_IDLE;
      inflight_vld  <= 1'b0;
      inflight_addr <= '0;
      inst_valid    <= 1'b0;
      inst_addr     <= '0;
      inst_data     <= '0;
      fetch_cnt     <= '0;
    end else begin
      // mem_ce is already low on a flush, so the returning word is dropped.
      inflight_vld <= mem_ce;
      if (mem_ce) begin
        inflight_addr <= pc_addr;
      end

      if (branch_true) begin
        inst_valid <= 1'b0;
        state      <= S_RUN;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (!stall) begin
              if (inflight_vld) begin
                inst_valid <= 1'b1;
                inst_addr  <= ret_entry.addr;
                inst_data  <= ret_entry.data;
                fetch_cnt  <= fetch_cnt + CNT_W'(1);
              end else begin
                inst_valid <= 1'b0;
              end
            end else if (inflight_vld) begin
              // Output holds; the live return is parked in the skid entry.
              state <= S_SKID;
            end
          end
          S_SKID: begin
            if (!stall) begin
              inst_valid <= skid_vld;
              inst_addr  <= skid_dout.addr;
              inst_data  <= skid_dout.data;
              fetch_cnt  <= fetch_cnt + CNT_W'(skid_vld);
              state      <= S_RUN;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_inst_fetch_resp                                          |
// | Purpose    : Self-checking bench for inst_fetch_resp. Directed stimulus  |
// |              pushes hand-computed expected instructions into a queue; a  |
// |              separate monitor pops and compares each newly delivered     |
// |              instruction. Registered outputs are also spot-checked.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_resp;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_addr;
  logic              stall;
  logic              branch_true;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic [CNT_W-1:0]  fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  inst_fetch_resp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .stall       (stall),
    .branch_true (branch_true),
    .mem_ce      (mem_ce),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word at address A is A + 0x100, one cycle after mem_ce.
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_ce) mem_rdata <= mem_addr + 32'h100;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Apply inputs for one cycle, then wait to mid-cycle. Registered outputs
  // seen afterwards are the result of the edge that ended the previous cycle.
  task automatic drive(input logic r, input logic [31:0] pc, input logic s, input logic b);
    @(posedge clk);
    #1;
    rst         = r;
    pc_addr     = pc;
    stall       = s;
    branch_true = b;
    @(negedge clk);
  endtask

  // Monitor: an instruction is newly delivered when inst_valid is high after
  // an edge at which reset, stall and flush were all inactive.
  initial begin : monitor
    logic rst_q, stall_q, br_q;
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(posedge clk);
      rst_q   = rst;
      stall_q = stall;
      br_q    = branch_true;
      @(negedge clk);
      if (rst_q && !stall_q && !br_q && inst_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: got addr=%h data=%h, required no delivery",
                   inst_addr, inst_data);
        end else begin
          e = exp_q.pop_front();
          if ({inst_addr, inst_data} !== e) begin
            n_bad++;
            $display("FAIL out_order: got addr=%h data=%h, required addr=%h data=%h",
                     inst_addr, inst_data, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b0; pc_addr = 32'h40; stall = 1'b0; branch_true = 1'b0;

    // Reset for three cycles
    drive(0, 32'h40, 0, 0);  check("rst_mem_ce_0", 32'(mem_ce), 0);
    drive(0, 32'h40, 0, 0);  check("rst_mem_ce_1", 32'(mem_ce), 0);
    drive(0, 32'h40, 0, 0);  check("rst_mem_ce_2", 32'(mem_ce), 0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_cnt",   32'(fetch_cnt), 0);
    check("rst_addr",  inst_addr, 0);
    check("rst_data",  inst_data, 0);

    // Streaming 0..5
    drive(1, 32'h0, 0, 0); push(32'h0, 32'h100);
    check("idle_mem_ce", 32'(mem_ce), 1);
    check("post_rst_valid", 32'(inst_valid), 0);
    drive(1, 32'h1, 0, 0); push(32'h1, 32'h101);
    check("idle_no_output", 32'(inst_valid), 0);
    drive(1, 32'h2, 0, 0); push(32'h2, 32'h102);
    drive(1, 32'h3, 0, 0); push(32'h3, 32'h103);
    drive(1, 32'h4, 0, 0); push(32'h4, 32'h104);
    drive(1, 32'h5, 0, 0); push(32'h5, 32'h105);
    check("stream_cnt", 32'(fetch_cnt), 4);
    check("stream_addr", inst_addr, 32'h3);

    // Stall three cycles with addr 5 in flight
    drive(1, 32'h6, 1, 0);
    check("stall_mem_ce_0", 32'(mem_ce), 0);
    check("stall_addr_0", inst_addr, 32'h4);
    check("stall_cnt", 32'(fetch_cnt), 5);
    drive(1, 32'h6, 1, 0);
    check("stall_mem_ce_1", 32'(mem_ce), 0);
    check("stall_addr_1", inst_addr, 32'h4);
    drive(1, 32'h6, 1, 0);
    check("stall_mem_ce_2", 32'(mem_ce), 0);
    check("stall_data_2", inst_data, 32'h104);
    drive(1, 32'h6, 0, 0);
    check("drain_no_issue", 32'(mem_ce), 0);
    check("drain_hold", inst_addr, 32'h4);
    drive(1, 32'h6, 0, 0); push(32'h6, 32'h106);
    check("after_drain_issue", 32'(mem_ce), 1);
    check("drain_addr", inst_addr, 32'h5);
    check("drain_cnt", 32'(fetch_cnt), 6);
    drive(1, 32'h7, 0, 0); push(32'h7, 32'h107);
    drive(1, 32'h8, 0, 0); push(32'h8, 32'h108);
    drive(1, 32'h9, 0, 0);

    // Flush with addr 9 in flight, redirect to 0x20
    drive(1, 32'h9, 0, 1);
    check("flush_mem_ce", 32'(mem_ce), 0);
    check("pre_flush_cnt", 32'(fetch_cnt), 9);
    drive(1, 32'h20, 0, 0); push(32'h20, 32'h120);
    check("redirect_issue", 32'(mem_ce), 1);
    check("flush_gap_0", 32'(inst_valid), 0);
    drive(1, 32'h21, 0, 0);
    check("flush_gap_1", 32'(inst_valid), 0);

    // Flush while in the skid state with stall held high
    drive(1, 32'h22, 1, 0);
    check("redirect_addr", inst_addr, 32'h20);
    check("redirect_cnt", 32'(fetch_cnt), 10);
    drive(1, 32'h22, 1, 1);
    check("skid_flush_mem_ce", 32'(mem_ce), 0);
    drive(1, 32'h30, 0, 0); push(32'h30, 32'h130);
    check("skid_flush_run", 32'(mem_ce), 1);
    check("skid_flush_valid", 32'(inst_valid), 0);
    check("skid_flush_cnt", 32'(fetch_cnt), 10);

    // Stream to 17 deliveries total: 4-bit counter wraps to 1
    drive(1, 32'h31, 0, 0); push(32'h31, 32'h131);
    drive(1, 32'h32, 0, 0); push(32'h32, 32'h132);
    drive(1, 32'h33, 0, 0); push(32'h33, 32'h133);
    drive(1, 32'h34, 0, 0); push(32'h34, 32'h134);
    drive(1, 32'h35, 0, 0); push(32'h35, 32'h135);
    drive(1, 32'h36, 0, 0); push(32'h36, 32'h136);
    drive(1, 32'h37, 0, 0);
    drive(1, 32'h37, 0, 1);
    check("wrap_cnt", 32'(fetch_cnt), 1);
    check("wrap_addr", inst_addr, 32'h36);

    // Reset in mid-operation discards the in-flight read
    drive(1, 32'h50, 0, 0);
    check("pre_rst_valid", 32'(inst_valid), 0);
    drive(0, 32'h51, 0, 0);
    check("mid_rst_mem_ce", 32'(mem_ce), 0);
    drive(0, 32'h51, 0, 0);
    check("mid_rst_valid", 32'(inst_valid), 0);
    check("mid_rst_cnt", 32'(fetch_cnt), 0);
    check("mid_rst_addr", inst_addr, 0);
    drive(1, 32'h52, 1, 0);
    drive(1, 32'h52, 1, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
